// File: rtl/proc_control_fsm_if.sv
// Control bundle between the multicycle control unit and the processor datapath.
// The controller consumes the IR fields and drives register enables and bus selects.
interface proc_control_fsm_if;
    logic       run;
    logic [8:0] ir;
    logic       gnz;
    logic       ir_in;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic       done;
    logic [1:0] tstep;

    modport master (
        input  run, ir, gnz,
        output ir_in, r_in, r_out, din_out, g_out, a_in, g_in, add_sub,
               addr_in, dout_in, w_d, done, tstep
    );

    modport slave (
        output run, ir, gnz,
        input  ir_in, r_in, r_out, din_out, g_out, a_in, g_in, add_sub,
               addr_in, dout_in, w_d, done, tstep
    );
endinterface

// File: rtl/proc_control_fsm.sv
// Multicycle control unit: steps each IR instruction through T0..T3, with an
// optional wait in T2 for ld. All outputs decode combinationally from state and IR.
module proc_control_fsm #(
    parameter int LD_WAIT = 1,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    proc_control_fsm_if.master  bus
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    localparam logic [CNT_W-1:0] LD_WAIT_C = CNT_W'(LD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    tstep_t           tstep_q, tstep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] op, x, y;
    logic [7:0] x_onehot, y_onehot;

    assign op = bus.ir[8:6];
    assign x  = bus.ir[5:3];
    assign y  = bus.ir[2:0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign x_onehot[gi] = (x == 3'(gi));
            assign y_onehot[gi] = (y == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstep_q <= T0;
            cnt_q   <= '0;
        end else begin
            tstep_q <= tstep_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tstep_d     = tstep_q;
        cnt_d       = cnt_q;
        bus.ir_in   = 1'b0;
        bus.r_in    = 8'h00;
        bus.r_out   = 8'h00;
        bus.din_out = 1'b0;
        bus.g_out   = 1'b0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.add_sub = 1'b0;
        bus.addr_in = 1'b0;
        bus.dout_in = 1'b0;
        bus.w_d     = 1'b0;
        bus.done    = 1'b0;

        case (tstep_q)
            T0: begin
                bus.ir_in = bus.run;
                if (bus.run) tstep_d = T1;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        bus.r_out = y_onehot;
                        bus.r_in  = x_onehot;
                        bus.done  = 1'b1;
                        tstep_d   = T0;
                    end
                    OP_MVI: begin
                        bus.din_out = 1'b1;
                        bus.r_in    = x_onehot;
                        bus.done    = 1'b1;
                        tstep_d     = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.r_out = x_onehot;
                        bus.a_in  = 1'b1;
                        tstep_d   = T2;
                    end
                    OP_LD, OP_ST: begin
                        bus.r_out   = y_onehot;
                        bus.addr_in = 1'b1;
                        cnt_d       = '0;
                        tstep_d     = T2;
                    end
                    OP_MVNZ: begin
                        if (bus.gnz) begin
                            bus.r_out = y_onehot;
                            bus.r_in  = x_onehot;
                        end
                        bus.done = 1'b1;
                        tstep_d  = T0;
                    end
                    default: begin
                        bus.done = 1'b1;
                        tstep_d  = T0;
                    end
                endcase
            end
            T2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        bus.r_out   = y_onehot;
                        bus.g_in    = 1'b1;
                        bus.add_sub = (op == OP_SUB);
                        tstep_d     = T3;
                    end
                    // Memory read latency: hold T2 silently until the counter reaches LD_WAIT.
                    OP_LD: begin
                        if (cnt_q == LD_WAIT_C) tstep_d = T3;
                        else                    cnt_d   = cnt_q + CNT_ONE;
                    end
                    OP_ST: begin
                        bus.r_out   = x_onehot;
                        bus.dout_in = 1'b1;
                        bus.w_d     = 1'b1;
                        bus.done    = 1'b1;
                        tstep_d     = T0;
                    end
                    default: tstep_d = T0;
                endcase
            end
            T3: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        bus.g_out = 1'b1;
                        bus.r_in  = x_onehot;
                        bus.done  = 1'b1;
                        tstep_d   = T0;
                    end
                    OP_LD: begin
                        bus.din_out = 1'b1;
                        bus.r_in    = x_onehot;
                        bus.done    = 1'b1;
                        tstep_d     = T0;
                    end
                    default: tstep_d = T0;
                endcase
            end
            default: tstep_d = T0;
        endcase
    end

    assign bus.tstep = tstep_q;
endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: walks every opcode step by step and compares
// the full output vector against hand-derived values.
module tb_proc_control_fsm;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    proc_control_fsm_if bus ();

    proc_control_fsm #(.LD_WAIT(2), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] F_DIN  = 9'h100;
    localparam logic [8:0] F_GOUT = 9'h080;
    localparam logic [8:0] F_AIN  = 9'h040;
    localparam logic [8:0] F_GIN  = 9'h020;
    localparam logic [8:0] F_SUB  = 9'h010;
    localparam logic [8:0] F_ADDR = 9'h008;
    localparam logic [8:0] F_DOUT = 9'h004;
    localparam logic [8:0] F_WD   = 9'h002;
    localparam logic [8:0] F_DONE = 9'h001;
    localparam logic [8:0] F_NONE = 9'h000;

    // Packed view: {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done, Tstep}
    logic [27:0] obs;
    logic [27:0] exp_v;
    assign obs = {bus.ir_in, bus.r_in, bus.r_out, bus.din_out, bus.g_out, bus.a_in,
                  bus.g_in, bus.add_sub, bus.addr_in, bus.dout_in, bus.w_d, bus.done,
                  bus.tstep};

    function automatic logic [27:0] ev(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic [8:0] fl,
                                       input logic [1:0] ts);
        return {irin, rin, rout, fl, ts};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #3;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle got %h exp %h", obs, exp_v); end
        bus.run = 1'b1;
        #1;
        exp_v = ev(1'b1, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_irin got %h exp %h", obs, exp_v); end
        bus.run = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_mvi;
        tick(); bus.run = 1'b1; bus.ir = 9'b001_010_000; #1;
        exp_v = ev(1'b1, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mvi_t0 got %h exp %h", obs, exp_v); end
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h04, 8'h00, F_DIN | F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mvi_t1 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mvi_after got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_sub;
        tick(); bus.run = 1'b1; bus.ir = 9'b011_001_011; #1;
        exp_v = ev(1'b1, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sub_t0 got %h exp %h", obs, exp_v); end
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h02, F_AIN, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sub_t1 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h08, F_GIN | F_SUB, 2'd2);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sub_t2 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h02, 8'h00, F_GOUT | F_DONE, 2'd3);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sub_t3 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sub_after got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_add;
        tick(); bus.run = 1'b1; bus.ir = 9'b010_101_111;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h20, F_AIN, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL add_t1 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h80, F_GIN, 2'd2);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL add_t2 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h20, 8'h00, F_GOUT | F_DONE, 2'd3);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL add_t3 got %h exp %h", obs, exp_v); end
        tick();
    endtask

    task automatic test_short_ops;
        bus.gnz = 1'b0;
        tick(); bus.run = 1'b1; bus.ir = 9'b110_000_101;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mvnz_gnz0 got %h exp %h", obs, exp_v); end
        bus.gnz = 1'b1;
        tick(); bus.run = 1'b1;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h01, 8'h20, F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mvnz_gnz1 got %h exp %h", obs, exp_v); end
        bus.gnz = 1'b0;
        tick(); bus.run = 1'b1; bus.ir = 9'b000_011_110;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h08, 8'h40, F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mv_t1 got %h exp %h", obs, exp_v); end
        tick(); bus.run = 1'b1; bus.ir = 9'b111_000_000;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL nop_t1 got %h exp %h", obs, exp_v); end
        tick();
    endtask

    task automatic test_ld;
        tick(); bus.run = 1'b1; bus.ir = 9'b100_100_110;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h40, F_ADDR, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ld_t1 got %h exp %h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd2);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ld_wait%0d got %h exp %h", i, obs, exp_v); end
        end
        tick(); #1;
        exp_v = ev(1'b0, 8'h10, 8'h00, F_DIN | F_DONE, 2'd3);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ld_t3 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ld_after got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_st;
        tick(); bus.run = 1'b1; bus.ir = 9'b101_111_000;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h00, 8'h01, F_ADDR, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL st_t1 got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h80, F_DOUT | F_WD | F_DONE, 2'd2);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL st_t2 got %h exp %h", obs, exp_v); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL st_idle%0d got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back;
        tick(); bus.run = 1'b1; bus.ir = 9'b000_001_010;
        tick(); #1;
        exp_v = ev(1'b0, 8'h02, 8'h04, F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_mv got %h exp %h", obs, exp_v); end
        tick(); #1;
        exp_v = ev(1'b1, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_fetch got %h exp %h", obs, exp_v); end
        bus.ir = 9'b001_111_000;
        tick(); bus.run = 1'b0; #1;
        exp_v = ev(1'b0, 8'h80, 8'h00, F_DIN | F_DONE, 2'd1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_mvi got %h exp %h", obs, exp_v); end
        tick();
    endtask

    task automatic test_reset_mid;
        tick(); bus.run = 1'b1; bus.ir = 9'b010_000_001;
        tick(); bus.run = 1'b0;
        tick(); #1;
        exp_v = ev(1'b0, 8'h00, 8'h02, F_GIN, 2'd2);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rstmid_t2 got %h exp %h", obs, exp_v); end
        rst = 1'b1; #1;
        exp_v = ev(1'b0, 8'h00, 8'h00, F_NONE, 2'd0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rstmid_async got %h exp %h", obs, exp_v); end
        tick(); rst = 1'b0;
        tick(); #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rstmid_nodone got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        rst     = 1'b1;
        bus.run = 1'b0;
        bus.ir  = 9'h000;
        bus.gnz = 1'b0;
        test_reset();
        test_mvi();
        test_sub();
        test_add();
        test_short_ops();
        test_ld();
        test_st();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
